// File: rtl/moore_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : moore_pattern_detector
// Description : Serial Moore-style pattern detector with a programmable
//               pattern, selectable overlapping / non-overlapping detection
//               and a saturating match counter.
//
//   Ports
//     clock       in   single clock, all state changes on the rising edge
//     reset       in   synchronous, active-high reset (highest priority)
//     in          in   serial data bit, sampled only when valid=1
//     valid       in   qualifies in for the current cycle
//     load        in   captures pattern_in / overlap_in and restarts detection
//     pattern_in  in   [PATTERN_WIDTH] target pattern, MSB received first
//     overlap_in  in   1 = overlapping detection, 0 = non-overlapping
//     y           out  Moore match flag, decoded from state only
//     match_count out  [COUNT_WIDTH] saturating number of matches
//     state       out  [2] current FSM state (IDLE/FILL/HUNT/MATCH)
//
// Revision    : 1.0 - initial release
// ============================================================================
module moore_pattern_detector #(
  parameter int PATTERN_WIDTH = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in,
  input  logic                     valid,
  input  logic                     load,
  input  logic [PATTERN_WIDTH-1:0] pattern_in,
  input  logic                     overlap_in,
  output logic                     y,
  output logic [COUNT_WIDTH-1:0]   match_count,
  output logic [1:0]               state
);

  // fill ranges over 0..PATTERN_WIDTH inclusive
  localparam int c_FILL_W = $clog2(PATTERN_WIDTH + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PATTERN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    HUNT  = 2'b10,
    MATCH = 2'b11
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [PATTERN_WIDTH-1:0] r_pat, w_pat_nxt;
  logic                     r_ovl, w_ovl_nxt;
  logic [PATTERN_WIDTH-1:0] r_sh, w_sh_nxt;
  logic [c_FILL_W-1:0]      r_fill, w_fill_nxt;
  logic [COUNT_WIDTH-1:0]   r_count, w_count_nxt;

  // Shift register and fill level as they would be after accepting 'in'
  logic [PATTERN_WIDTH-1:0] w_sh_upd;
  logic [c_FILL_W-1:0]      w_fill_upd;
  logic                     w_match;

  assign w_sh_upd   = {r_sh[PATTERN_WIDTH-2:0], in};
  assign w_fill_upd = (r_fill == c_FILL_FULL) ? r_fill : r_fill + 1'b1;
  assign w_match    = (w_fill_upd == c_FILL_FULL) && (w_sh_upd == r_pat);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_ovl   <= 1'b1;
      r_sh    <= '0;
      r_fill  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_ovl   <= w_ovl_nxt;
      r_sh    <= w_sh_nxt;
      r_fill  <= w_fill_nxt;
      r_count <= w_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_ovl_nxt   = r_ovl;
    w_sh_nxt    = r_sh;
    w_fill_nxt  = r_fill;
    w_count_nxt = r_count;

    if (load) begin
      // The bit presented alongside load is deliberately dropped.
      w_pat_nxt   = pattern_in;
      w_ovl_nxt   = overlap_in;
      w_sh_nxt    = '0;
      w_fill_nxt  = '0;
      w_count_nxt = '0;
      w_state_nxt = IDLE;
    end else if (valid) begin
      w_sh_nxt = w_sh_upd;
      if (w_match) begin
        w_state_nxt = MATCH;
        if (!(&r_count)) begin
          w_count_nxt = r_count + 1'b1;
        end
        // Non-overlapping mode forgets the matched bits by emptying fill;
        // the stale shift contents are harmless because a new match needs
        // fill to reach full again, i.e. PATTERN_WIDTH fresh bits.
        w_fill_nxt = r_ovl ? c_FILL_FULL : '0;
      end else begin
        w_fill_nxt = w_fill_upd;
        if (w_fill_upd == '0) begin
          w_state_nxt = IDLE;
        end else if (w_fill_upd < c_FILL_FULL) begin
          w_state_nxt = FILL;
        end else begin
          w_state_nxt = HUNT;
        end
      end
    end else if (r_state == MATCH) begin
      // Leaving MATCH on an idle cycle keeps y to a single-cycle pulse.
      w_state_nxt = r_ovl ? HUNT : IDLE;
    end
  end

  assign y           = (r_state == MATCH);
  assign match_count = r_count;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_moore_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_pattern_detector
// Description : Scoreboard bench for moore_pattern_detector. Two instances
//               (8-bit and 2-bit match counters) share the stimulus; a
//               bit-history reference model predicts every cycle's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_pattern_detector;

  localparam int PW = 4;

  logic          clock;
  logic          reset;
  logic          in;
  logic          valid;
  logic          load;
  logic [PW-1:0] pattern_in;
  logic          overlap_in;

  logic          y_a;
  logic [7:0]    cnt_a;
  logic [1:0]    state_a;
  logic          y_b;
  logic [1:0]    cnt_b;
  logic [1:0]    state_b;

  moore_pattern_detector #(.PATTERN_WIDTH(PW), .COUNT_WIDTH(8)) dut_a (
    .clock(clock), .reset(reset), .in(in), .valid(valid), .load(load),
    .pattern_in(pattern_in), .overlap_in(overlap_in),
    .y(y_a), .match_count(cnt_a), .state(state_a)
  );

  moore_pattern_detector #(.PATTERN_WIDTH(PW), .COUNT_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .in(in), .valid(valid), .load(load),
    .pattern_in(pattern_in), .overlap_in(overlap_in),
    .y(y_b), .match_count(cnt_b), .state(state_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: keeps the list of accepted bits since the last restart
  // --------------------------------------------------------------------------
  bit          hist[$];
  logic [PW-1:0] m_pat;
  bit          m_ovl;
  int          m_cnt_a, m_cnt_b;
  int          m_state;

  typedef struct {
    int y;
    int st;
    int ca;
    int cb;
  } exp_t;
  exp_t sb[$];

  function automatic int category(input int n);
    if (n == 0) return 0;
    if (n < PW) return 1;
    return 2;
  endfunction

  task automatic model_step(input bit r, input bit ld, input bit v, input bit b,
                            input logic [PW-1:0] p, input bit o);
    bit hit;
    if (r) begin
      hist.delete(); m_pat = '0; m_ovl = 1'b1;
      m_cnt_a = 0; m_cnt_b = 0; m_state = 0;
    end else if (ld) begin
      hist.delete(); m_pat = p; m_ovl = o;
      m_cnt_a = 0; m_cnt_b = 0; m_state = 0;
    end else if (v) begin
      hist.push_back(b);
      if (hist.size() > PW) void'(hist.pop_front());
      hit = (hist.size() == PW);
      for (int i = 0; i < hist.size(); i++)
        if (hist[i] != m_pat[PW-1-i]) hit = 1'b0;
      if (hit) begin
        m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
        m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
        if (!m_ovl) hist.delete();
        m_state = 3;
      end else begin
        m_state = category(hist.size());
      end
    end else begin
      m_state = category(hist.size());
    end
  endtask

  // Drive one cycle, update the model at the edge and queue the prediction.
  task automatic step(input bit r, input bit ld, input bit v, input bit b,
                      input logic [PW-1:0] p, input bit o);
    exp_t e;
    @(negedge clock);
    reset = r; load = ld; valid = v; in = b; pattern_in = p; overlap_in = o;
    @(posedge clock);
    model_step(r, ld, v, b, p, o);
    e.y  = (m_state == 3) ? 1 : 0;
    e.st = m_state;
    e.ca = m_cnt_a;
    e.cb = m_cnt_b;
    sb.push_back(e);
    #1;
  endtask

  task automatic bit_in(input bit b);
    step(1'b0, 1'b0, 1'b1, b, 4'h0, 1'b0);
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic load_pat(input logic [PW-1:0] p, input bit o);
    step(1'b0, 1'b1, 1'b0, 1'b0, p, o);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compares DUT outputs against the queued prediction each cycle
  // --------------------------------------------------------------------------
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_y_a",     int'(y_a),     e.y);
      chk("sb_state_a", int'(state_a), e.st);
      chk("sb_cnt_a",   int'(cnt_a),   e.ca);
      chk("sb_y_b",     int'(y_b),     e.y);
      chk("sb_state_b", int'(state_b), e.st);
      chk("sb_cnt_b",   int'(cnt_b),   e.cb);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [6:0] stream;
    stream = 7'b1011011;
    reset = 1'b1; load = 1'b0; valid = 1'b0; in = 1'b0;
    pattern_in = '0; overlap_in = 1'b0;

    // Reset held two cycles with valid data toggling
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0);
    chk("rst_y", int'(y_a), 0); chk("rst_state", int'(state_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("rst_y2", int'(y_a), 0); chk("rst_state2", int'(state_a), 0);
    idle_cycle();
    chk("rst_rel_y", int'(y_a), 0); chk("rst_rel_state", int'(state_a), 0);
    chk("rst_rel_cnt", int'(cnt_a), 0);

    // Overlapping detection of 1011 in 1011011
    load_pat(4'b1011, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream[i]);
      if (i == 3) chk("ovl_y_bit4", int'(y_a), 1);
      if (i == 2) chk("ovl_y_bit5", int'(y_a), 0);
    end
    chk("ovl_y_bit7", int'(y_a), 1);
    chk("ovl_cnt", int'(cnt_a), 2);

    // Non-overlapping detection
    load_pat(4'b1011, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream[i]);
      if (i == 3) chk("novl_y_bit4", int'(y_a), 1);
    end
    chk("novl_y_bit7", int'(y_a), 0);
    chk("novl_state_bit7", int'(state_a), 1);
    chk("novl_cnt", int'(cnt_a), 1);

    // Gap between matches
    load_pat(4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) bit_in(1'b1);
    chk("gap_y_bit4", int'(y_a), 1);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("gap_y_idle", int'(y_a), 0);
      chk("gap_state_idle", int'(state_a), 2);
    end
    bit_in(1'b1);
    chk("gap_y_bit5", int'(y_a), 1);
    chk("gap_cnt", int'(cnt_a), 2);

    // Saturation of the 2-bit counter
    load_pat(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1);
      if (i >= 3) chk("sat_y_pulse", int'(y_b), 1);
    end
    chk("sat_cnt_b", int'(cnt_b), 3);
    chk("sat_cnt_a", int'(cnt_a), 5);

    // Load beats valid; the bit with load is discarded
    load_pat(4'b1011, 1'b1);
    bit_in(1'b1); bit_in(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1);
    chk("ld_pri_state", int'(state_a), 0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("ld_pri_fill", int'(state_a), 1);
    chk("ld_pri_y", int'(y_a), 0);

    // Reset beats load while in MATCH; pattern returns to zero
    load_pat(4'b1011, 1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("rl_in_match", int'(y_a), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0);
    chk("rl_y", int'(y_a), 0); chk("rl_state", int'(state_a), 0);
    chk("rl_cnt", int'(cnt_a), 0);
    for (int i = 0; i < 4; i++) bit_in(1'b0);
    chk("rl_pat_zero_match", int'(y_a), 1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom),
           4'($urandom), 1'($urandom));
    end

    @(negedge clock);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
